// File: rtl/lm_sm_sequencer_if.sv
// Bus between the decode stage and the LM/SM sequencer.
// The master side presents the instruction; the slave side (the sequencer)
// returns the per-transfer address, register index, strobes and pipeline
// control.
interface lm_sm_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
);
    logic              start;
    logic              isStore;
    logic [NREG-1:0]   regList;
    logic [ADDR_W-1:0] baseAddr;
    logic [ADDR_W-1:0] memAddr;
    logic [IDX_W-1:0]  regIndex;
    logic              accessValid;
    logic              writeMem;
    logic              regWrite;
    logic              stall;
    logic              busy;
    logic              done;

    modport master (
        output start, isStore, regList, baseAddr,
        input  memAddr, regIndex, accessValid, writeMem, regWrite,
               stall, busy, done
    );

    modport slave (
        input  start, isStore, regList, baseAddr,
        output memAddr, regIndex, accessValid, writeMem, regWrite,
               stall, busy, done
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer.
// Walks the latched register mask from bit 0 upward, issuing one memory
// transfer per set bit at consecutive addresses, and stalls the front of
// the pipeline until the final transfer issues.
module lm_sm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int IDX_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    lm_sm_sequencer_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [NREG-1:0]   mask;
    logic [ADDR_W-1:0] addr;
    logic              store;
    logic [ADDR_W-1:0] hold_addr;
    logic [IDX_W-1:0]  hold_idx;

    logic [IDX_W-1:0]  low_idx;
    logic [NREG-1:0]   mask_next;
    logic              in_run;
    logic              access_valid;
    logic              last;

    // Fixed-priority encoder: lowest set bit of the remaining mask wins.
    always_comb begin
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Remaining-mask bookkeeping: drop the lowest set bit, and flag the final
    // cycle when at most one bit is left (this also covers an empty mask).
    always_comb begin
        mask_next    = mask & (mask - NREG'(1));
        in_run       = (state == RUN);
        access_valid = in_run && (mask != '0);
        last         = (mask_next == '0);
    end

    // Sequencer state: latch the instruction in IDLE, step through transfers
    // in RUN, and remember the most recent transfer so address/index hold in
    // IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            addr      <= '0;
            store     <= 1'b0;
            hold_addr <= '0;
            hold_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask  <= bus.regList;
                        addr  <= bus.baseAddr;
                        store <= bus.isStore;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (access_valid) begin
                        mask      <= mask_next;
                        addr      <= addr + ADDR_W'(1);
                        hold_addr <= addr;
                        hold_idx  <= low_idx;
                    end
                    if (last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, except the IDLE stall
    // which must follow start in the same cycle; reset forces that low too.
    always_comb begin
        bus.memAddr     = in_run ? addr : hold_addr;
        bus.regIndex    = in_run ? low_idx : hold_idx;
        bus.accessValid = access_valid;
        bus.writeMem    = access_valid && store;
        bus.regWrite    = access_valid && !store;
        bus.busy        = in_run;
        bus.done        = in_run && last;
        bus.stall       = in_run ? !last : (bus.start && !reset);
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed self-checking bench for the LM/SM sequencer.
// Inputs change 1 ns after each rising edge; outputs are checked 2 ns after it.
module tb_lm_sm_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   busy_cycles;

    lm_sm_sequencer_if #(.ADDR_W(16), .NREG(8), .IDX_W(3)) bus_if ();

    lm_sm_sequencer #(.ADDR_W(16), .NREG(8), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and on mismatch count the error and report.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (input-drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check every output of the sequencer against expected values.
    task automatic chk_all(input string tag, input logic [15:0] addr, input logic [2:0] idx,
                           input logic av, input logic wm, input logic rw,
                           input logic st, input logic bz, input logic dn);
        chk({tag, ".memAddr"},     32'(bus_if.memAddr),     32'(addr));
        chk({tag, ".regIndex"},    32'(bus_if.regIndex),    32'(idx));
        chk({tag, ".accessValid"}, 32'(bus_if.accessValid), 32'(av));
        chk({tag, ".writeMem"},    32'(bus_if.writeMem),    32'(wm));
        chk({tag, ".regWrite"},    32'(bus_if.regWrite),    32'(rw));
        chk({tag, ".stall"},       32'(bus_if.stall),       32'(st));
        chk({tag, ".busy"},        32'(bus_if.busy),        32'(bz));
        chk({tag, ".done"},        32'(bus_if.done),        32'(dn));
    endtask

    initial begin
        logic [2:0] sm_idx [4];
        sm_idx[0] = 3'd0;
        sm_idx[1] = 3'd2;
        sm_idx[2] = 3'd5;
        sm_idx[3] = 3'd7;
        checks = 0;
        errors = 0;

        // Reset state
        reset           = 1'b1;
        bus_if.start    = 1'b0;
        bus_if.isStore  = 1'b0;
        bus_if.regList  = '0;
        bus_if.baseAddr = '0;
        #3;
        chk_all("reset", 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // SM, regList 1010_0101 at 0x0100
        step();
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b1;
        bus_if.regList  = 8'b1010_0101;
        bus_if.baseAddr = 16'h0100;
        #1;
        chk("sm.c0.stall", 32'(bus_if.stall), 32'd1);
        chk("sm.c0.busy",  32'(bus_if.busy),  32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            bus_if.start   = 1'b0;
            bus_if.regList = 8'hFF;
            #1;
            chk_all($sformatf("sm.c%0d", k + 1), 16'h0100 + 16'(k), sm_idx[k],
                    1, 1, 0, (k != 3), 1, (k == 3));
        end
        step();
        #1;
        chk("sm.after.busy", 32'(bus_if.busy), 32'd0);
        chk("sm.after.hold_addr", 32'(bus_if.memAddr), 32'h0103);
        chk("sm.after.hold_idx",  32'(bus_if.regIndex), 32'd7);

        // LM, all registers at 0x0010
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b0;
        bus_if.regList  = 8'hFF;
        bus_if.baseAddr = 16'h0010;
        #1;
        chk("lm.c0.stall", 32'(bus_if.stall), 32'd1);
        busy_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            bus_if.start = 1'b0;
            #1;
            if (bus_if.busy) busy_cycles++;
            chk_all($sformatf("lm.c%0d", k + 1), 16'h0010 + 16'(k), 3'(k),
                    1, 0, 1, (k != 7), 1, (k == 7));
        end
        step();
        #1;
        if (bus_if.busy) busy_cycles++;
        chk("lm.busy_cycles", 32'(busy_cycles), 32'd8);

        // Address wrap-around from 0xFFFE
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b0;
        bus_if.regList  = 8'b0000_0111;
        bus_if.baseAddr = 16'hFFFE;
        step();
        bus_if.start = 1'b0;
        #1;
        chk_all("wrap.c1", 16'hFFFE, 3'd0, 1, 0, 1, 1, 1, 0);
        step();
        #1;
        chk_all("wrap.c2", 16'hFFFF, 3'd1, 1, 0, 1, 1, 1, 0);
        step();
        #1;
        chk_all("wrap.c3", 16'h0000, 3'd2, 1, 0, 1, 0, 1, 1);
        step();

        // Empty mask
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b1;
        bus_if.regList  = 8'h00;
        bus_if.baseAddr = 16'h0123;
        #1;
        chk("empty.c0.stall", 32'(bus_if.stall), 32'd1);
        step();
        bus_if.start = 1'b0;
        #1;
        chk("empty.c1.accessValid", 32'(bus_if.accessValid), 32'd0);
        chk("empty.c1.writeMem",    32'(bus_if.writeMem),    32'd0);
        chk("empty.c1.regWrite",    32'(bus_if.regWrite),    32'd0);
        chk("empty.c1.stall",       32'(bus_if.stall),       32'd0);
        chk("empty.c1.busy",        32'(bus_if.busy),        32'd1);
        chk("empty.c1.done",        32'(bus_if.done),        32'd1);
        step();
        #1;
        chk("empty.c2.busy",  32'(bus_if.busy),  32'd0);
        chk("empty.c2.stall", 32'(bus_if.stall), 32'd0);

        // Single bit with start held high: back-to-back acceptance
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b1;
        bus_if.regList  = 8'b1000_0000;
        bus_if.baseAddr = 16'h0300;
        step();
        bus_if.isStore  = 1'b0;
        bus_if.regList  = 8'b0000_0011;
        bus_if.baseAddr = 16'h0400;
        #1;
        chk_all("b2b.c1", 16'h0300, 3'd7, 1, 1, 0, 0, 1, 1);
        step();
        #1;
        chk("b2b.c2.busy",  32'(bus_if.busy),  32'd0);
        chk("b2b.c2.stall", 32'(bus_if.stall), 32'd1);
        step();
        bus_if.start    = 1'b1;
        bus_if.regList  = 8'hFF;
        bus_if.baseAddr = 16'h0777;
        #1;
        chk_all("b2b.c3", 16'h0400, 3'd0, 1, 0, 1, 1, 1, 0);
        step();
        bus_if.start = 1'b0;
        #1;
        chk_all("b2b.c4", 16'h0401, 3'd1, 1, 0, 1, 0, 1, 1);
        step();
        #1;
        chk("b2b.c5.busy",        32'(bus_if.busy),        32'd0);
        chk("b2b.c5.accessValid", 32'(bus_if.accessValid), 32'd0);

        // Asynchronous reset during the 2nd transfer of a full LM
        bus_if.start    = 1'b1;
        bus_if.isStore  = 1'b0;
        bus_if.regList  = 8'hFF;
        bus_if.baseAddr = 16'h0050;
        step();
        bus_if.start = 1'b0;
        step();
        #1;
        chk("rst.c2.regIndex", 32'(bus_if.regIndex), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all("rst.mid", 16'h0000, 3'd0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        #1;
        chk("rst.idle.busy", 32'(bus_if.busy), 32'd0);
        bus_if.start    = 1'b1;
        bus_if.regList  = 8'h01;
        bus_if.baseAddr = 16'h0200;
        step();
        bus_if.start = 1'b0;
        #1;
        chk_all("rst.after", 16'h0200, 3'd0, 1, 0, 1, 0, 1, 1);
        step();
        #1;
        chk("rst.after.busy", 32'(bus_if.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
